csr_commit_ctrl: RTL and testbench

Sequencer between the commit stage and the CSR unit. It accepts one CSR or system operation per commit from commit slot 0, issues it to the CSR file as a single-cycle request, and holds commit stalled while it waits for the response. It then returns write-back data, handles WFI sleep, and raises a post-write pipeline flush. It sits after `csr_interface` and before the CSR register file. It replaces combinational pass-through with a handshake that tolerates multi-cycle CSR responses.

---
 rtl/drac_pkg.sv | 27 ++
 rtl/csr_resp_timer.sv | 38 +++
 rtl/csr_commit_ctrl.sv | 177 +++++++++++++++++
 tb/tb_csr_commit_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drac_pkg.sv
// Shared core types: CSR commands and CSR commit-controller definitions.
package drac_pkg;

    localparam int CSR_ADDR_SIZE = 12;

    typedef enum logic [2:0] {
        CSR_READ,
        CSR_WRITE,
        CSR_SET,
        CSR_CLEAR,
        CSR_SYS,
        CSR_VSELVL,
        CSR_N2
    } csr_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        WFI,
        FLUSH
    } csr_ctrl_state_t;

    localparam int CSR_CTRL_TIMER_W = 8;
    localparam int CSR_CTRL_FLUSH_W = 3;

endpackage

// File: rtl/csr_resp_timer.sv
// Loadable response-wait counter; tc_o marks the last cycle before
// the outstanding CSR request is abandoned.
module csr_resp_timer
    import drac_pkg::*;
#(
    parameter int RESP_TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CSR_CTRL_TIMER_W-1:0] TC =
        CSR_CTRL_TIMER_W'(RESP_TIMEOUT - 1);

    logic [CSR_CTRL_TIMER_W-1:0] cnt_q;
    logic [CSR_CTRL_TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == TC);

endmodule

// File: rtl/csr_commit_ctrl.sv
// Commit-to-CSR sequencer: one request per op, waits for the response,
// then write-back, WFI sleep or a post-write flush.
module csr_commit_ctrl
    import drac_pkg::*;
#(
    parameter int RESP_TIMEOUT = 64,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     csr_ena_i,
    input  csr_cmd_t                 csr_cmd_i,
    input  logic [CSR_ADDR_SIZE-1:0] csr_addr_i,
    input  logic [63:0]              csr_wdata_i,
    input  logic                     kill_i,
    output logic                     csr_req_valid_o,
    output csr_cmd_t                 csr_req_cmd_o,
    output logic [CSR_ADDR_SIZE-1:0] csr_req_addr_o,
    output logic [63:0]              csr_req_data_o,
    input  logic                     csr_resp_valid_i,
    input  logic [63:0]              csr_rdata_i,
    input  logic                     csr_xcpt_i,
    input  logic                     csr_wfi_i,
    input  logic                     irq_pending_i,
    output logic                     commit_stall_o,
    output logic                     wb_valid_o,
    output logic [63:0]              wb_data_o,
    output logic                     retire_o,
    output logic                     flush_o,
    output logic                     xcpt_o,
    output logic                     timeout_o
);

    localparam logic [CSR_CTRL_FLUSH_W-1:0] FLUSH_LAST =
        CSR_CTRL_FLUSH_W'(FLUSH_CYCLES);

    csr_ctrl_state_t state_q, state_d;
    csr_cmd_t cmd_q, cmd_d;
    logic [CSR_ADDR_SIZE-1:0] addr_q, addr_d;
    logic [63:0] data_q, data_d;
    logic [63:0] wb_data_q, wb_data_d;
    logic [CSR_CTRL_FLUSH_W-1:0] fcnt_q, fcnt_d;
    logic killed_q, killed_d;
    logic wb_valid_q, wb_valid_d;
    logic retire_q, retire_d;
    logic xcpt_q, xcpt_d;
    logic timeout_q, timeout_d;
    logic flush_q, flush_d;
    logic tc;

    csr_resp_timer #(
        .RESP_TIMEOUT(RESP_TIMEOUT)
    ) u_timer (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clr_i(state_q == REQ),
        .en_i (state_q == WAIT),
        .tc_o (tc)
    );

    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        addr_d          = addr_q;
        data_d          = data_q;
        wb_data_d       = wb_data_q;
        fcnt_d          = fcnt_q;
        killed_d        = killed_q;
        wb_valid_d      = 1'b0;
        retire_d        = 1'b0;
        xcpt_d          = 1'b0;
        timeout_d       = 1'b0;
        flush_d         = 1'b0;
        csr_req_valid_o = 1'b0;
        commit_stall_o  = 1'b1;
        unique case (state_q)
            IDLE: begin
                commit_stall_o = csr_ena_i;
                if (csr_ena_i && !kill_i) begin
                    cmd_d   = csr_cmd_i;
                    addr_d  = csr_addr_i;
                    data_d  = csr_wdata_i;
                    state_d = REQ;
                end
            end
            REQ: begin
                csr_req_valid_o = 1'b1;
                killed_d        = kill_i;
                state_d         = WAIT;
            end
            WAIT: begin
                if (kill_i)
                    killed_d = 1'b1;
                // A response beats a same-cycle timeout.
                if (csr_resp_valid_i) begin
                    if (killed_q || kill_i) begin
                        state_d = IDLE;
                    end else if (csr_xcpt_i) begin
                        xcpt_d  = 1'b1;
                        state_d = IDLE;
                    end else if (csr_wfi_i) begin
                        state_d = WFI;
                    end else begin
                        wb_valid_d = 1'b1;
                        retire_d   = 1'b1;
                        wb_data_d  = csr_rdata_i;
                        if (cmd_q == CSR_READ || cmd_q == CSR_N2) begin
                            state_d = IDLE;
                        end else begin
                            fcnt_d  = '0;
                            state_d = FLUSH;
                        end
                    end
                end else if (tc) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            WFI: begin
                if (irq_pending_i || kill_i) begin
                    retire_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            FLUSH: begin
                if (fcnt_q == FLUSH_LAST) begin
                    state_d = IDLE;
                end else begin
                    flush_d = 1'b1;
                    fcnt_d  = fcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cmd_q      <= CSR_READ;
            addr_q     <= '0;
            data_q     <= '0;
            wb_data_q  <= '0;
            fcnt_q     <= '0;
            killed_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            retire_q   <= 1'b0;
            xcpt_q     <= 1'b0;
            timeout_q  <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wb_data_q  <= wb_data_d;
            fcnt_q     <= fcnt_d;
            killed_q   <= killed_d;
            wb_valid_q <= wb_valid_d;
            retire_q   <= retire_d;
            xcpt_q     <= xcpt_d;
            timeout_q  <= timeout_d;
            flush_q    <= flush_d;
        end
    end

    assign csr_req_cmd_o  = cmd_q;
    assign csr_req_addr_o = addr_q;
    assign csr_req_data_o = data_q;
    assign wb_valid_o     = wb_valid_q;
    assign wb_data_o      = wb_data_q;
    assign retire_o       = retire_q;
    assign xcpt_o         = xcpt_q;
    assign timeout_o      = timeout_q;
    assign flush_o        = flush_q;

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Directed bench for csr_commit_ctrl; completion pulses are checked
// against a scoreboard of expected events with their cycle.
module tb_csr_commit_ctrl;
    import drac_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b0;
    csr_cmd_t cmd = CSR_READ;
    logic [CSR_ADDR_SIZE-1:0] addr = '0;
    logic [63:0] wdata = '0;
    logic kill = 1'b0;
    logic resp = 1'b0;
    logic [63:0] rdata = '0;
    logic xcpt_in = 1'b0;
    logic wfi_in = 1'b0;
    logic irq = 1'b0;

    logic req_valid;
    csr_cmd_t req_cmd;
    logic [CSR_ADDR_SIZE-1:0] req_addr;
    logic [63:0] req_data;
    logic stall, wb_valid, retire, flush, xcpt, tmo;
    logic [63:0] wb_data;

    typedef struct {
        bit wb;
        bit ret;
        bit xc;
        bit to;
        logic [63:0] data;
        int cyc;
    } ev_t;

    ev_t sb[$];
    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int c0;

    csr_commit_ctrl #(
        .RESP_TIMEOUT(4),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .csr_ena_i       (ena),
        .csr_cmd_i       (cmd),
        .csr_addr_i      (addr),
        .csr_wdata_i     (wdata),
        .kill_i          (kill),
        .csr_req_valid_o (req_valid),
        .csr_req_cmd_o   (req_cmd),
        .csr_req_addr_o  (req_addr),
        .csr_req_data_o  (req_data),
        .csr_resp_valid_i(resp),
        .csr_rdata_i     (rdata),
        .csr_xcpt_i      (xcpt_in),
        .csr_wfi_i       (wfi_in),
        .irq_pending_i   (irq),
        .commit_stall_o  (stall),
        .wb_valid_o      (wb_valid),
        .wb_data_o       (wb_data),
        .retire_o        (retire),
        .flush_o         (flush),
        .xcpt_o          (xcpt),
        .timeout_o       (tmo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string tag,
                                logic [63:0] obs,
                                logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h",
                   tag, obs, exp);
        end
    endfunction

    task automatic go(int n);
        repeat (n) @(negedge clk);
    endtask

    // Protocol: the CSR file never answers in the request cycle.
    always @(posedge clk)
        if (!rst && req_valid)
            chk("resp_in_req", 64'(resp), 64'd0);

    always @(negedge clk) begin
        #2;
        if (!rst && (wb_valid || retire || xcpt || tmo)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected",
                    64'({wb_valid, retire, xcpt, tmo}), 64'd0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("sb_cyc", 64'(cyc), 64'(e.cyc));
                chk("sb_wb", 64'(wb_valid), 64'(e.wb));
                chk("sb_ret", 64'(retire), 64'(e.ret));
                chk("sb_xcpt", 64'(xcpt), 64'(e.xc));
                chk("sb_tmo", 64'(tmo), 64'(e.to));
                if (e.wb)
                    chk("sb_data", wb_data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=running expected=done");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        go(2);
        #1;
        chk("rst_stall", 64'(stall), 0);
        chk("rst_req_valid", 64'(req_valid), 0);
        chk("rst_req_addr", 64'(req_addr), 0);
        chk("rst_req_data", req_data, 0);
        chk("rst_wb", 64'({wb_valid, retire, flush, xcpt, tmo}), 0);
        chk("rst_wb_data", wb_data, 0);
        go(1);
        rst = 1'b0;

        // READ mcycle, response at cycle 2
        go(1);
        c0 = cyc;
        ena = 1'b1;
        cmd = CSR_READ;
        addr = 12'hB00;
        #1 chk("rd_stall_c0", 64'(stall), 1);
        sb.push_back('{1, 1, 0, 0, 64'h1234, c0 + 3});
        go(1);
        ena = 1'b0;
        #1;
        chk("rd_req_valid_c1", 64'(req_valid), 1);
        chk("rd_req_addr", 64'(req_addr), 64'hB00);
        chk("rd_req_cmd", 64'(req_cmd), 64'(CSR_READ));
        go(1);
        resp = 1'b1;
        rdata = 64'h1234;
        #1 chk("rd_req_valid_c2", 64'(req_valid), 0);
        go(1);
        resp = 1'b0;
        #1;
        chk("rd_stall_c3", 64'(stall), 0);
        chk("rd_flush_c3", 64'(flush), 0);
        chk("rd_wb_data", wb_data, 64'h1234);
        go(1);
        #1 chk("rd_flush_c4", 64'(flush), 0);

        // WRITE mstatus, response at cycle 5
        go(1);
        c0 = cyc;
        ena = 1'b1;
        cmd = CSR_WRITE;
        addr = 12'h300;
        wdata = 64'h8;
        sb.push_back('{1, 1, 0, 0, 64'hA, c0 + 6});
        go(1);
        ena = 1'b0;
        #1;
        chk("wr_req_valid_c1", 64'(req_valid), 1);
        chk("wr_req_data", req_data, 64'h8);
        for (int i = 2; i <= 4; i++) begin
            go(1);
            #1;
            chk("wr_req_valid_wait", 64'(req_valid), 0);
            chk("wr_stall_wait", 64'(stall), 1);
        end
        go(1);
        resp = 1'b1;
        rdata = 64'hA;
        go(1);
        resp = 1'b0;
        #1;
        chk("wr_flush_c6", 64'(flush), 0);
        chk("wr_stall_c6", 64'(stall), 1);
        go(1);
        #1 chk("wr_flush_c7", 64'(flush), 1);
        go(1);
        #1;
        chk("wr_flush_c8", 64'(flush), 1);
        chk("wr_stall_c8", 64'(stall), 1);
        go(1);
        #1;
        chk("wr_flush_c9", 64'(flush), 0);
        chk("wr_stall_c9", 64'(stall), 0);

        // Access fault
        go(1);
        c0 = cyc;
        ena = 1'b1;
        cmd = CSR_SET;
        sb.push_back('{0, 0, 1, 0, 64'h0, c0 + 3});
        go(1);
        ena = 1'b0;
        go(1);
        resp = 1'b1;
        xcpt_in = 1'b1;
        go(1);
        resp = 1'b0;
        xcpt_in = 1'b0;
        #1;
        chk("xc_stall", 64'(stall), 0);
        chk("xc_flush", 64'(flush), 0);

        // WFI sleep, wake on irq at cycle 20
        go(1);
        c0 = cyc;
        ena = 1'b1;
        cmd = CSR_SYS;
        sb.push_back('{0, 1, 0, 0, 64'h0, c0 + 21});
        go(1);
        ena = 1'b0;
        go(1);
        resp = 1'b1;
        wfi_in = 1'b1;
        go(1);
        resp = 1'b0;
        wfi_in = 1'b0;
        go(7);
        resp = 1'b1;
        rdata = 64'hDEAD;
        #1 chk("wfi_stall_c10", 64'(stall), 1);
        go(1);
        resp = 1'b0;
        go(8);
        #1 chk("wfi_stall_c19", 64'(stall), 1);
        go(1);
        irq = 1'b1;
        #1 chk("wfi_stall_c20", 64'(stall), 1);
        go(1);
        irq = 1'b0;
        #1 chk("wfi_stall_c21", 64'(stall), 0);

        // Kill at cycle 2, response at cycle 4
        go(1);
        ena = 1'b1;
        cmd = CSR_WRITE;
        go(1);
        ena = 1'b0;
        go(1);
        kill = 1'b1;
        go(1);
        kill = 1'b0;
        go(1);
        resp = 1'b1;
        #1 chk("kill_stall_c4", 64'(stall), 1);
        go(1);
        resp = 1'b0;
        #1;
        chk("kill_stall_c5", 64'(stall), 0);
        chk("kill_flush_c5", 64'(flush), 0);

        // Kill and response together in WAIT
        go(1);
        ena = 1'b1;
        cmd = CSR_READ;
        go(1);
        ena = 1'b0;
        go(1);
        kill = 1'b1;
        resp = 1'b1;
        go(1);
        kill = 1'b0;
        resp = 1'b0;
        #1 chk("kr_stall", 64'(stall), 0);

        // Timeout, then immediate re-accept
        go(1);
        c0 = cyc;
        ena = 1'b1;
        cmd = CSR_READ;
        sb.push_back('{0, 0, 0, 1, 64'h0, c0 + 6});
        go(1);
        ena = 1'b0;
        go(4);
        #1 chk("to_stall_c5", 64'(stall), 1);
        go(1);
        ena = 1'b1;
        addr = 12'h123;
        sb.push_back('{1, 1, 0, 0, 64'h55, c0 + 9});
        go(1);
        ena = 1'b0;
        #1;
        chk("to_reaccept", 64'(req_valid), 1);
        chk("to_req_addr", 64'(req_addr), 64'h123);
        go(1);
        resp = 1'b1;
        rdata = 64'h55;
        go(1);
        resp = 1'b0;

        // Kill with ena in IDLE: not accepted
        go(1);
        ena = 1'b1;
        kill = 1'b1;
        #1 chk("ki_stall", 64'(stall), 1);
        go(1);
        ena = 1'b0;
        kill = 1'b0;
        #1;
        chk("ki_req_valid", 64'(req_valid), 0);
        chk("ki_stall_after", 64'(stall), 0);

        // Reset mid-operation
        go(1);
        ena = 1'b1;
        cmd = CSR_WRITE;
        go(1);
        ena = 1'b0;
        go(1);
        rst = 1'b1;
        #1;
        chk("mr_stall", 64'(stall), 0);
        chk("mr_wb_data", wb_data, 0);
        go(1);
        rst = 1'b0;
        go(1);
        resp = 1'b1;
        go(1);
        resp = 1'b0;
        #1;
        chk("mr_idle", 64'({stall, req_valid, flush}), 0);

        go(3);
        chk("sb_empty", 64'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
